// File: rtl/bot_io_regs_pkg.sv
// Shared constants for the Rojobot port-mapped I/O block: port offsets, bank
// stride, status/ctrl bit positions and interrupt FSM encoding.
package bot_io_pkg;

  localparam logic [3:0] OFS_BTN  = 4'h0;
  localparam logic [3:0] OFS_SW   = 4'h1;
  localparam logic [3:0] OFS_LED  = 4'h2;
  localparam logic [3:0] OFS_DIG3 = 4'h3;
  localparam logic [3:0] OFS_DIG0 = 4'h6;
  localparam logic [3:0] OFS_DP   = 4'h7;
  localparam logic [3:0] OFS_MOT  = 4'h9;
  localparam logic [3:0] OFS_LOCX = 4'hA;
  localparam logic [3:0] OFS_LOCY = 4'hB;
  localparam logic [3:0] OFS_INFO = 4'hC;
  localparam logic [3:0] OFS_SENS = 4'hD;
  localparam logic [3:0] OFS_STAT = 4'hE;
  localparam logic [3:0] OFS_CTRL = 4'hF;

  localparam int BANK_STRIDE = 16;

  localparam int STAT_PEND  = 0;
  localparam int STAT_OVR   = 1;
  localparam int CTRL_INTEN = 0;

  typedef enum logic {
    INTR_IDLE = 1'b0,
    INTR_PEND = 1'b1
  } intr_state_e;

  function automatic logic [7:0] port_addr(input int bank, input logic [3:0] ofs);
    return 8'(bank * BANK_STRIDE) | {4'h0, ofs};
  endfunction

  // Within a bank, digit 4k+3 sits at the lowest offset and digit 4k at the highest.
  function automatic logic [3:0] dig_ofs(input int d);
    return OFS_DIG0 - 4'(d % 4);
  endfunction

endpackage

// File: rtl/bot_io_regs_if.sv
// PicoBlaze port bus as seen by the I/O register file.
interface bot_io_regs_if;
  logic       Wr_Strobe;
  logic       Rd_Strobe;
  logic       interrupt_ack;
  logic [7:0] AddrIn;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       interrupt;

  modport master (
    output Wr_Strobe, Rd_Strobe, interrupt_ack, AddrIn, DataIn,
    input  DataOut, interrupt
  );

  modport slave (
    input  Wr_Strobe, Rd_Strobe, interrupt_ack, AddrIn, DataIn,
    output DataOut, interrupt
  );
endinterface

// File: rtl/bot_io_regs_intr_ctl.sv
// Update-interrupt controller: IDLE/PEND request FSM, sticky overrun flag and
// the interrupt enable bit.
module bot_io_intr_ctl
  import bot_io_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic upd,
  input  logic ack,
  input  logic clr_pend,
  input  logic clr_ovr,
  input  logic en_we,
  input  logic en_d,
  output logic pend,
  output logic ovr,
  output logic int_en
);

  intr_state_e state, state_nx;
  logic        ovr_nx;
  logic        cleared, raise;

  assign cleared = ack | clr_pend;
  assign raise   = upd & int_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INTR_IDLE;
      ovr    <= 1'b0;
      int_en <= 1'b0;
    end else begin
      state <= state_nx;
      ovr   <= ovr_nx;
      if (en_we) int_en <= en_d;
    end
  end

  // A fresh update wins over a same-cycle clear so that event is not lost.
  always_comb begin
    state_nx = state;
    ovr_nx   = ovr;
    case (state)
      INTR_IDLE: if (raise) state_nx = INTR_PEND;
      INTR_PEND: begin
        if (raise)        state_nx = INTR_PEND;
        else if (cleared) state_nx = INTR_IDLE;
      end
      default: state_nx = INTR_IDLE;
    endcase
    if (clr_ovr) ovr_nx = 1'b0;
    if ((state == INTR_PEND) && upd && !cleared) ovr_nx = 1'b1;
  end

  assign pend = (state == INTR_PEND);

endmodule

// File: rtl/bot_io_regs.sv
// Port-mapped I/O register file between the Rojobot PicoBlaze and the board /
// botsim: write holding regs, atomic commit on botsim update, snapshot, read mux.
module bot_io_regs
  import bot_io_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIG_W       = 5,
  parameter int LED_W       = 16,
  parameter int SW_W        = 16,
  parameter int BTN_W       = 6,
  parameter int COMMIT_MODE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  bot_io_regs_if.slave                bus,
  input  logic [7:0]                  LocX,
  input  logic [7:0]                  LocY,
  input  logic [7:0]                  BotInfo,
  input  logic [7:0]                  Sensors,
  input  logic                        upd_sysregs,
  input  logic [BTN_W-1:0]            db_btns,
  input  logic [SW_W-1:0]             db_sw,
  output logic [7:0]                  MotCtl,
  output logic [LED_W-1:0]            led,
  output logic [NUM_DIGITS*DIG_W-1:0] dig,
  output logic [NUM_DIGITS-1:0]       dp
);

  localparam int LED_B = LED_W / 8;
  localparam int SW_B  = SW_W / 8;
  localparam int DIG_B = NUM_DIGITS / 4;

  logic [7:0] addr, din, rd;
  logic [3:0] ofs;
  logic       wr, lo_bank;
  logic       stat_we, ctrl_we;
  logic       pend, ovr, int_en;
  logic       unused_rd;

  assign addr      = bus.AddrIn;
  assign din       = bus.DataIn;
  assign wr        = bus.Wr_Strobe;
  assign ofs       = addr[3:0];
  assign unused_rd = bus.Rd_Strobe;
  // Buttons, motor control and snapshot are mirrored in banks 0 and 1 only.
  assign lo_bank   = (addr[7:5] == 3'b000);
  assign stat_we   = wr && (addr == port_addr(0, OFS_STAT));
  assign ctrl_we   = wr && (addr == port_addr(0, OFS_CTRL));

  logic [LED_B-1:0][7:0]            led_h, led_c;
  logic [NUM_DIGITS-1:0][DIG_W-1:0] dig_h, dig_c;
  logic [DIG_B-1:0][3:0]            dp_h, dp_c;
  logic [7:0]                       mot_h, mot_c;
  logic [3:0][7:0]                  snap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_h <= '0;
      dig_h <= '0;
      dp_h  <= '0;
      mot_h <= '0;
    end else if (wr) begin
      for (int k = 0; k < LED_B; k++)
        if (addr == port_addr(k, OFS_LED)) led_h[k] <= din;
      for (int d = 0; d < NUM_DIGITS; d++)
        if (addr == port_addr(d / 4, dig_ofs(d))) dig_h[d] <= din[DIG_W-1:0];
      for (int k = 0; k < DIG_B; k++)
        if (addr == port_addr(k, OFS_DP)) dp_h[k] <= din[3:0];
      if (lo_bank && ofs == OFS_MOT) mot_h <= din;
    end
  end

  // Committed copy sees the pre-edge holding value, so a write landing in the
  // same cycle as the update pulse waits for the next pulse.
  generate
    if (COMMIT_MODE == 0) begin : g_held
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          led_c <= '0;
          dig_c <= '0;
          dp_c  <= '0;
          mot_c <= '0;
        end else if (upd_sysregs) begin
          led_c <= led_h;
          dig_c <= dig_h;
          dp_c  <= dp_h;
          mot_c <= mot_h;
        end
      end
    end else begin : g_live
      assign led_c = led_h;
      assign dig_c = dig_h;
      assign dp_c  = dp_h;
      assign mot_c = mot_h;
    end
  endgenerate

  assign led    = led_c;
  assign dig    = dig_c;
  assign dp     = dp_c;
  assign MotCtl = mot_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           snap <= '0;
    else if (upd_sysregs) snap <= {Sensors, BotInfo, LocY, LocX};
  end

  always_comb begin
    rd = '0;
    case (ofs)
      OFS_BTN: if (lo_bank) rd[BTN_W-1:0] = db_btns;
      OFS_SW: begin
        for (int k = 0; k < SW_B; k++)
          if (addr[7:4] == 4'(k)) rd = db_sw[k*8 +: 8];
      end
      OFS_LOCX, OFS_LOCY, OFS_INFO, OFS_SENS:
        if (lo_bank) rd = snap[2'(ofs - OFS_LOCX)];
      OFS_STAT: begin
        if (addr[7:4] == 4'h0) begin
          rd[STAT_PEND] = pend;
          rd[STAT_OVR]  = ovr;
        end
      end
      OFS_CTRL: if (addr[7:4] == 4'h0) rd[CTRL_INTEN] = int_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.DataOut <= '0;
    else        bus.DataOut <= rd;
  end

  bot_io_intr_ctl u_intr (
    .clk      (clk),
    .rst_n    (reset),
    .upd      (upd_sysregs),
    .ack      (bus.interrupt_ack),
    .clr_pend (stat_we & din[STAT_PEND]),
    .clr_ovr  (stat_we & din[STAT_OVR]),
    .en_we    (ctrl_we),
    .en_d     (din[CTRL_INTEN]),
    .pend     (pend),
    .ovr      (ovr),
    .int_en   (int_en)
  );

  assign bus.interrupt = pend;

endmodule

// File: tb/tb_bot_io_regs.sv
// Bench for bot_io_regs: held-commit and live-commit instances share stimulus and
// are compared each cycle against an address-indexed behavioural model.
module tb_bot_io_regs;

  localparam int ND = 8, DW = 5, LW = 16, SWW = 16, BW = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           wr_s = 0, rd_s = 0, ack = 0, upd = 0;
  logic [7:0]     addr = 0, din = 0, locx = 0, locy = 0, info = 0, sens = 0;
  logic [BW-1:0]  btns = 0;
  logic [SWW-1:0] sw = 0;
  logic [7:0]     mot0, mot1;
  logic [LW-1:0]  led0, led1;
  logic [ND*DW-1:0] dig0, dig1;
  logic [ND-1:0]  dp0, dp1;

  bot_io_regs_if if0 ();
  bot_io_regs_if if1 ();
  assign if0.Wr_Strobe = wr_s;  assign if1.Wr_Strobe = wr_s;
  assign if0.Rd_Strobe = rd_s;  assign if1.Rd_Strobe = rd_s;
  assign if0.interrupt_ack = ack;  assign if1.interrupt_ack = ack;
  assign if0.AddrIn = addr;  assign if1.AddrIn = addr;
  assign if0.DataIn = din;   assign if1.DataIn = din;

  bot_io_regs #(.NUM_DIGITS(ND), .DIG_W(DW), .LED_W(LW), .SW_W(SWW), .BTN_W(BW), .COMMIT_MODE(0)) u0 (
    .clk(clk), .reset(rst_n), .bus(if0), .LocX(locx), .LocY(locy), .BotInfo(info), .Sensors(sens),
    .upd_sysregs(upd), .db_btns(btns), .db_sw(sw), .MotCtl(mot0), .led(led0), .dig(dig0), .dp(dp0));

  bot_io_regs #(.NUM_DIGITS(ND), .DIG_W(DW), .LED_W(LW), .SW_W(SWW), .BTN_W(BW), .COMMIT_MODE(1)) u1 (
    .clk(clk), .reset(rst_n), .bus(if1), .LocX(locx), .LocY(locy), .BotInfo(info), .Sensors(sens),
    .upd_sysregs(upd), .db_btns(btns), .db_sw(sw), .MotCtl(mot1), .led(led1), .dig(dig1), .dp(dp1));

  int checks = 0, errors = 0;
  bit run = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: every write is remembered by port address; commit snapshots the whole map.
  logic [7:0] mh [256];
  logic [7:0] mc [256];
  logic [7:0] moth, motc;
  logic [7:0] snap [4];
  logic       m_pend, m_ovr, m_en;
  logic [7:0] e_dout;
  logic       st_wr, cl;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int bk = int'(a[7:4]);
    int o  = int'(a[3:0]);
    logic [7:0] r = 8'h00;
    if (o == 0 && bk < 2)                 r = 8'(btns);
    else if (o == 1 && bk < SWW / 8)      r = sw[bk*8 +: 8];
    else if (o >= 10 && o <= 13 && bk < 2) r = snap[o-10];
    else if (a == 8'h0E)                  r = {6'b0, m_ovr, m_pend};
    else if (a == 8'h0F)                  r = {7'b0, m_en};
    return r;
  endfunction

  function automatic logic [7:0] m_byte(input bit live, input int a);
    return live ? mh[a] : mc[a];
  endfunction

  function automatic logic [LW-1:0] e_led(input bit live);
    logic [LW-1:0] r = '0;
    for (int k = 0; k < LW / 8; k++) r[k*8 +: 8] = m_byte(live, k*16 + 2);
    return r;
  endfunction

  function automatic logic [ND*DW-1:0] e_dig(input bit live);
    logic [ND*DW-1:0] r = '0;
    logic [7:0] v;
    for (int i = 0; i < ND; i++) begin
      v = m_byte(live, (i / 4) * 16 + 6 - (i % 4));
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [ND-1:0] e_dp(input bit live);
    logic [ND-1:0] r = '0;
    logic [7:0] v;
    for (int k = 0; k < ND / 4; k++) begin
      v = m_byte(live, k*16 + 7);
      r[k*4 +: 4] = v[3:0];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin mh[i] = 0; mc[i] = 0; end
      for (int i = 0; i < 4; i++) snap[i] = 0;
      moth = 0; motc = 0; m_pend = 0; m_ovr = 0; m_en = 0; e_dout = 0;
    end else begin
      e_dout = m_read(addr);
      st_wr  = wr_s && addr == 8'h0E;
      cl     = ack || (st_wr && din[0]);
      if (st_wr && din[1]) m_ovr = 0;
      if (m_pend && upd && !cl) m_ovr = 1;
      m_pend = (upd && m_en) ? 1'b1 : (cl ? 1'b0 : m_pend);
      if (upd) begin
        mc = mh; motc = moth;
        snap[0] = locx; snap[1] = locy; snap[2] = info; snap[3] = sens;
      end
      if (wr_s) begin
        mh[addr] = din;
        if (addr == 8'h09 || addr == 8'h19) moth = din;
        if (addr == 8'h0F) m_en = din[0];
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("dout0", 64'(if0.DataOut), 64'(e_dout));
      chk("dout1", 64'(if1.DataOut), 64'(e_dout));
      chk("irq0", 64'(if0.interrupt), 64'(m_pend));
      chk("irq1", 64'(if1.interrupt), 64'(m_pend));
      chk("led0", 64'(led0), 64'(e_led(0)));
      chk("led1", 64'(led1), 64'(e_led(1)));
      chk("dig0", 64'(dig0), 64'(e_dig(0)));
      chk("dig1", 64'(dig1), 64'(e_dig(1)));
      chk("dp0", 64'(dp0), 64'(e_dp(0)));
      chk("dp1", 64'(dp1), 64'(e_dp(1)));
      chk("mot0", 64'(mot0), 64'(motc));
      chk("mot1", 64'(mot1), 64'(moth));
    end
  end

  task automatic step(); @(negedge clk); endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_s = 1; addr = a; din = d; step(); wr_s = 0;
  endtask
  task automatic pulse_upd(); upd = 1; step(); upd = 0; endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    addr = a; step(); chk(nm, 64'(if0.DataOut), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    rst_n = 1; run = 1;
    chk("rst_led", 64'(led0), 64'h0);
    chk("rst_irq", 64'(if0.interrupt), 64'h0);

    // held commit: nothing moves until the update pulse
    wr(8'h02, 8'h55); wr(8'h12, 8'hA0); wr(8'h09, 8'h0F);
    chk("led_held", 64'(led0), 64'h0);
    chk("mot_held", 64'(mot0), 64'h0);
    chk("led_live", 64'(led1), 64'hA055);
    pulse_upd();
    chk("led_commit", 64'(led0), 64'hA055);
    chk("mot_commit", 64'(mot0), 64'h0F);
    wr_s = 1; addr = 8'h02; din = 8'h11; upd = 1; step(); wr_s = 0; upd = 0;
    chk("coinc_held", 64'(led0), 64'hA055);
    pulse_upd();
    chk("coinc_commit", 64'(led0), 64'hA011);

    // digits and decimal points
    wr(8'h13, 8'h1F); wr(8'h06, 8'h07); wr(8'h05, 8'hFF); wr(8'h17, 8'h09);
    pulse_upd();
    chk("dig7", 64'(dig0[39:35]), 64'h1F);
    chk("dig0", 64'(dig0[4:0]), 64'h07);
    chk("dig1_mask", 64'(dig0[9:5]), 64'h1F);
    chk("dp_hi", 64'(dp0), 64'h90);

    // snapshot holds the value seen at the update
    locx = 8'h20; locy = 8'h44; pulse_upd(); locx = 8'h30;
    rd(8'h0A, 8'h20, "snap_locx");
    rd(8'h1B, 8'h44, "snap_locy_b1");

    // interrupt / overrun
    wr(8'h0F, 8'h01);
    pulse_upd(); chk("irq_set", 64'(if0.interrupt), 64'h1);
    pulse_upd(); rd(8'h0E, 8'h03, "stat_ovr");
    ack = 1; step(); ack = 0;
    chk("irq_ack", 64'(if0.interrupt), 64'h0);
    rd(8'h0E, 8'h02, "stat_after_ack");
    wr(8'h0E, 8'h02); rd(8'h0E, 8'h00, "stat_clr_ovr");
    pulse_upd();
    upd = 1; ack = 1; step(); upd = 0; ack = 0;
    chk("upd_ack_irq", 64'(if0.interrupt), 64'h1);
    rd(8'h0E, 8'h01, "upd_ack_ovr");
    wr(8'h0F, 8'h00); pulse_upd();
    chk("en0_keep", 64'(if0.interrupt), 64'h1);
    wr(8'h0E, 8'h03);
    chk("clr_pend", 64'(if0.interrupt), 64'h0);
    pulse_upd();
    chk("en0_noraise", 64'(if0.interrupt), 64'h0);

    // read map, unmapped banks, live commit latency
    sw = 16'hBEEF; btns = 6'h2A;
    rd(8'h21, 8'h00, "unmapped_21");
    rd(8'h3F, 8'h00, "unmapped_3F");
    rd(8'h01, 8'hEF, "sw_b0");
    rd(8'h11, 8'hBE, "sw_b1");
    rd(8'h10, 8'h2A, "btn_b1");
    rd(8'h1E, 8'h00, "stat_b1");
    wr(8'h02, 8'h33);
    chk("live_led", 64'(led1[7:0]), 64'h33);
    rd_s = 1;
    for (int a = 0; a < 64; a++) begin addr = 8'(a); step(); end
    rd_s = 0;

    // reset in the middle of a pending request with an uncommitted write
    wr(8'h0F, 8'h01); pulse_upd();
    chk("irq_prerst", 64'(if0.interrupt), 64'h1);
    wr(8'h02, 8'h77);
    #2 rst_n = 0;
    #1;
    chk("rst_async_led", 64'(led0), 64'h0);
    chk("rst_async_irq", 64'(if0.interrupt), 64'h0);
    chk("rst_async_dout", 64'(if0.DataOut), 64'h0);
    step(); step();
    rst_n = 1;
    rd(8'h0E, 8'h00, "stat_after_rst");
    pulse_upd();
    chk("rst_no_commit", 64'(led0), 64'h0);
    chk("rst_no_irq", 64'(if0.interrupt), 64'h0);
    step();

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
